// File: rtl/bus_arbiter_pkg.sv
// ============================================================================
// Package : rosco_pkg
// Shared FSM encoding and constants for the two-master bus arbiter.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package rosco_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQUEST   = 3'd1,
    ST_WAIT_IDLE = 3'd2,
    ST_OWN       = 3'd3,
    ST_RELEASE   = 3'd4
  } arb_state_t;

  localparam int DEFAULT_MAX_TENURE = 255;
  localparam int SYNC_STAGES        = 2;
  localparam int TENURE_W           = 8;

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_sync2.sv
// ============================================================================
// Module : sync2
// Multi-flop synchronizer for one asynchronous request bit, clears on reset.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sync2
  import rosco_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module : bus_arbiter
// Two-master round-robin bus arbiter with tenure timeout, 68k-style BR/BG/BGACK.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bus_arbiter
  import rosco_pkg::*;
#(
  parameter int MAX_TENURE = DEFAULT_MAX_TENURE
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic [1:0] REQn,
  input  logic       ASn,
  input  logic       BGn,
  output logic       BRn,
  output logic       BGACKn,
  output logic [1:0] GNTn,
  output logic       TIMEOUT
);

  localparam logic [TENURE_W-1:0] TENURE_LIMIT = TENURE_W'(MAX_TENURE);

  logic [1:0]          sreq;
  arb_state_t          state, state_nxt;
  logic                winner, winner_nxt;
  logic                last_owner, last_owner_nxt;
  logic [TENURE_W-1:0] tenure, tenure_nxt;
  logic                br_n, br_n_nxt;
  logic                bgack_n, bgack_n_nxt;
  logic [1:0]          gnt_n, gnt_n_nxt;
  logic                timeout, timeout_nxt;

  // Requests are active-low and asynchronous; synchronize the active-high form.
  for (genvar i = 0; i < 2; i++) begin : g_sync
    sync2 u_sync (
      .clk   (CLK),
      .rst_n (RESETn),
      .d     (~REQn[i]),
      .q     (sreq[i])
    );
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state      <= ST_IDLE;
      winner     <= 1'b0;
      last_owner <= 1'b1;
      tenure     <= '0;
      br_n       <= 1'b1;
      bgack_n    <= 1'b1;
      gnt_n      <= 2'b11;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      winner     <= winner_nxt;
      last_owner <= last_owner_nxt;
      tenure     <= tenure_nxt;
      br_n       <= br_n_nxt;
      bgack_n    <= bgack_n_nxt;
      gnt_n      <= gnt_n_nxt;
      timeout    <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    winner_nxt     = winner;
    last_owner_nxt = last_owner;
    tenure_nxt     = tenure;
    br_n_nxt       = br_n;
    bgack_n_nxt    = bgack_n;
    gnt_n_nxt      = gnt_n;
    timeout_nxt    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (|sreq) begin
          // Both requesting: the master that did not own last goes first.
          winner_nxt = (&sreq) ? ~last_owner : sreq[1];
          br_n_nxt   = 1'b0;
          state_nxt  = ST_REQUEST;
        end
      end

      ST_REQUEST: begin
        if (!sreq[winner]) begin
          br_n_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (!BGn) begin
          state_nxt = ST_WAIT_IDLE;
        end
      end

      ST_WAIT_IDLE: begin
        if (ASn && !BGn) begin
          bgack_n_nxt       = 1'b0;
          br_n_nxt          = 1'b1;
          gnt_n_nxt         = 2'b11;
          gnt_n_nxt[winner] = 1'b0;
          last_owner_nxt    = winner;
          tenure_nxt        = '0;
          state_nxt         = ST_OWN;
        end
      end

      ST_OWN: begin
        if (tenure != TENURE_LIMIT) begin
          tenure_nxt = tenure + 1'b1;
        end
        if (!sreq[last_owner]) begin
          gnt_n_nxt = 2'b11;
          state_nxt = ST_RELEASE;
        end else if ((tenure == TENURE_LIMIT) && sreq[~last_owner]) begin
          gnt_n_nxt   = 2'b11;
          timeout_nxt = 1'b1;
          state_nxt   = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (ASn) begin
          bgack_n_nxt = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign BRn     = br_n;
  assign BGACKn  = bgack_n;
  assign GNTn    = gnt_n;
  assign TIMEOUT = timeout;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module : tb_bus_arbiter
// Scenario-driven bench for bus_arbiter with a grant scoreboard.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] req_n = 2'b11;
  logic       as_n = 1'b1;
  logic       bg_n = 1'b1;
  logic       br_n;
  logic       bgack_n;
  logic [1:0] gnt_n;
  logic       timeout;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];
  logic [1:0] prev_gnt = 2'b11;

  bus_arbiter #(.MAX_TENURE(8)) dut (
    .CLK     (clk),
    .RESETn  (rst_n),
    .REQn    (req_n),
    .ASn     (as_n),
    .BGn     (bg_n),
    .BRn     (br_n),
    .BGACKn  (bgack_n),
    .GNTn    (gnt_n),
    .TIMEOUT (timeout)
  );

  always #5 clk = ~clk;

  // Grant scoreboard plus per-cycle protocol invariants.
  always @(posedge clk) begin
    logic [1:0] e;
    #1;
    if (rst_n) begin
      checks++;
      if (gnt_n === 2'b00) begin
        errors++;
        $display("FAIL gnt_onehot: got GNTn=%b, required at most one bit low", gnt_n);
      end
      checks++;
      if (br_n === 1'b0 && bgack_n === 1'b0) begin
        errors++;
        $display("FAIL br_bgack_overlap: got BRn=%b BGACKn=%b, required not both low", br_n, bgack_n);
      end
      if (prev_gnt === 2'b11 && gnt_n !== 2'b11) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_grant: got GNTn=%b, required no grant", gnt_n);
        end else begin
          e = exp_q.pop_front();
          if (gnt_n !== e) begin
            errors++;
            $display("FAIL sb_grant: got GNTn=%b, required %b", gnt_n, e);
          end
        end
      end
    end
    prev_gnt = gnt_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_n = 2'b11;
    as_n  = 1'b1;
    bg_n  = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input logic [1:0] exp, input string name);
    for (int i = 0; i < 40 && gnt_n === 2'b11; i++) tick();
    checks++;
    if (gnt_n !== exp) begin
      errors++;
      $display("FAIL %s: got GNTn=%b, required %b", name, gnt_n, exp);
    end
  endtask

  task automatic drain(input string name);
    req_n = 2'b11;
    as_n  = 1'b1;
    for (int i = 0; i < 20 && (bgack_n !== 1'b1 || gnt_n !== 2'b11); i++) tick();
    checks++;
    if (bgack_n !== 1'b1 || gnt_n !== 2'b11) begin
      errors++;
      $display("FAIL %s: got BGACKn=%b GNTn=%b, required 1 11", name, bgack_n, gnt_n);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({br_n, bgack_n, gnt_n, timeout} !== 5'b11110) begin
      errors++;
      $display("FAIL reset_outputs: got BRn,BGACKn,GNTn,TIMEOUT=%b, required 11110",
               {br_n, bgack_n, gnt_n, timeout});
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    exp_q.push_back(2'b10);
    req_n = 2'b10;
    tick();
    checks++;
    if (br_n !== 1'b1) begin errors++; $display("FAIL single_br_e1: got BRn=%b, required 1", br_n); end
    tick();
    checks++;
    if (br_n !== 1'b1) begin errors++; $display("FAIL single_br_e2: got BRn=%b, required 1", br_n); end
    tick();
    checks++;
    if (br_n !== 1'b0) begin errors++; $display("FAIL single_br_e3: got BRn=%b, required 0", br_n); end
    repeat (3) tick();
    bg_n = 1'b0;
    tick();
    checks++;
    if ({br_n, bgack_n, gnt_n} !== 4'b0111) begin
      errors++;
      $display("FAIL single_wait_idle: got BRn,BGACKn,GNTn=%b, required 0111", {br_n, bgack_n, gnt_n});
    end
    tick();
    checks++;
    if ({br_n, bgack_n, gnt_n} !== 4'b1010) begin
      errors++;
      $display("FAIL single_own: got BRn,BGACKn,GNTn=%b, required 1010", {br_n, bgack_n, gnt_n});
    end
    drain("single_drain");
  endtask

  task automatic test_both();
    do_reset();
    bg_n = 1'b0;
    exp_q.push_back(2'b10);
    req_n = 2'b00;
    wait_grant(2'b10, "both_first_m0");
    exp_q.push_back(2'b01);
    req_n = 2'b01;
    for (int i = 0; i < 10 && gnt_n !== 2'b11; i++) tick();
    checks++;
    if ({br_n, bgack_n, gnt_n} !== 4'b1011) begin
      errors++;
      $display("FAIL both_release: got BRn,BGACKn,GNTn=%b, required 1011", {br_n, bgack_n, gnt_n});
    end
    tick();
    checks++;
    if ({br_n, bgack_n, gnt_n} !== 4'b1111) begin
      errors++;
      $display("FAIL both_idle: got BRn,BGACKn,GNTn=%b, required 1111", {br_n, bgack_n, gnt_n});
    end
    tick();
    checks++;
    if (br_n !== 1'b0) begin errors++; $display("FAIL both_rearb_br: got BRn=%b, required 0", br_n); end
    wait_grant(2'b01, "both_second_m1");
    drain("both_drain");
  endtask

  task automatic test_timeout();
    do_reset();
    bg_n = 1'b0;
    exp_q.push_back(2'b10);
    req_n = 2'b10;
    wait_grant(2'b10, "to_grant_m0");
    as_n  = 1'b0;
    req_n = 2'b00;
    exp_q.push_back(2'b01);
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (gnt_n !== 2'b10 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL to_hold_%0d: got GNTn=%b TIMEOUT=%b, required 10 0", i, gnt_n, timeout);
      end
    end
    tick();
    checks++;
    if ({gnt_n, timeout, bgack_n} !== 4'b1110) begin
      errors++;
      $display("FAIL to_revoke: got GNTn,TIMEOUT,BGACKn=%b, required 1110", {gnt_n, timeout, bgack_n});
    end
    tick();
    checks++;
    if (timeout !== 1'b0 || bgack_n !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse_end: got TIMEOUT=%b BGACKn=%b, required 0 0", timeout, bgack_n);
    end
    tick();
    checks++;
    if (bgack_n !== 1'b0) begin errors++; $display("FAIL to_as_hold: got BGACKn=%b, required 0", bgack_n); end
    as_n = 1'b1;
    tick();
    checks++;
    if (bgack_n !== 1'b1) begin errors++; $display("FAIL to_as_release: got BGACKn=%b, required 1", bgack_n); end
    wait_grant(2'b01, "to_next_m1");
    drain("to_drain");
  endtask

  task automatic test_no_competitor();
    do_reset();
    bg_n = 1'b0;
    exp_q.push_back(2'b10);
    req_n = 2'b10;
    wait_grant(2'b10, "nc_grant");
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (gnt_n !== 2'b10 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL nc_hold_%0d: got GNTn=%b TIMEOUT=%b, required 10 0", i, gnt_n, timeout);
      end
    end
    drain("nc_drain");
  endtask

  task automatic test_withdraw();
    do_reset();
    req_n = 2'b10;
    for (int i = 0; i < 10 && br_n !== 1'b0; i++) tick();
    checks++;
    if (br_n !== 1'b0) begin errors++; $display("FAIL wd_br_low: got BRn=%b, required 0", br_n); end
    req_n = 2'b11;
    tick();
    checks++;
    if (br_n !== 1'b0) begin errors++; $display("FAIL wd_br_e1: got BRn=%b, required 0", br_n); end
    tick();
    checks++;
    if (br_n !== 1'b0) begin errors++; $display("FAIL wd_br_e2: got BRn=%b, required 0", br_n); end
    tick();
    checks++;
    if (br_n !== 1'b1) begin errors++; $display("FAIL wd_br_e3: got BRn=%b, required 1", br_n); end
    bg_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (gnt_n !== 2'b11 || br_n !== 1'b1 || bgack_n !== 1'b1) begin
        errors++;
        $display("FAIL wd_idle_%0d: got GNTn=%b BRn=%b BGACKn=%b, required 11 1 1", i, gnt_n, br_n, bgack_n);
      end
    end
    bg_n = 1'b1;
  endtask

  task automatic test_reset_mid_own();
    do_reset();
    bg_n = 1'b0;
    exp_q.push_back(2'b10);
    req_n = 2'b10;
    wait_grant(2'b10, "rmo_grant");
    tick();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({br_n, bgack_n, gnt_n, timeout} !== 5'b11110) begin
      errors++;
      $display("FAIL rmo_async: got BRn,BGACKn,GNTn,TIMEOUT=%b, required 11110",
               {br_n, bgack_n, gnt_n, timeout});
    end
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.push_back(2'b10);
    wait_grant(2'b10, "rmo_resume");
    drain("rmo_drain");
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_timeout();
    test_no_competitor();
    test_withdraw();
    test_reset_mid_own();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending grants, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
